// File: rtl/inscache_pkg.sv
// inscache_pkg: shared geometry default and fetch FSM state type for the instruction cache.
package inscache_pkg;
  localparam int LINE_BITS_DEF = 6;
  typedef enum logic {S_IDLE, S_WAIT} state_e;
endpackage

// File: rtl/inscache_array.sv
// inscache_array: valid/tag/data line storage with one async read port and one sync write port.
module inscache_array
  import inscache_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int TAG_W = 30 - LINE_BITS
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [LINE_BITS-1:0] rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [31:0]          rd_data,
  input  logic                 we,
  input  logic [LINE_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [31:0]          wr_data
);
  localparam int N = 1 << LINE_BITS;
  logic [N-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [N], tag_d  [N];
  logic [31:0]      data_q [N], data_d [N];
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end
  // only the valid bits are reset; tag/data contents are don't-care until valid
  always_ff @(posedge clk_in) begin
    valid_q <= rst_in ? '0 : valid_d;
    tag_q   <= tag_d;
    data_q  <= data_d;
  end
endmodule

// File: rtl/inscache.sv
// inscache: direct-mapped instruction cache; combinational hits, single outstanding miss to memctrl.
module inscache
  import inscache_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        hit,
  output logic [31:0] hit_ins,
  output logic        is_fetch,
  output logic [31:0] fetch_addr,
  input  logic        is_back,
  input  logic [31:0] back_ins
);
  localparam int TAG_W = 30 - LINE_BITS;
  state_e      state_q, state_d;
  logic        is_fetch_q, is_fetch_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        rd_valid, bypass, fill, unused_pc;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0] rd_data;
  assign unused_pc = ^req_pc[1:0];
  inscache_array #(.LINE_BITS(LINE_BITS), .TAG_W(TAG_W)) u_array (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (req_pc[LINE_BITS+1:2]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .we      (fill),
    .wr_idx  (fetch_addr_q[LINE_BITS+1:2]),
    .wr_tag  (fetch_addr_q[31:LINE_BITS+2]),
    .wr_data (back_ins)
  );
  // returning word is forwarded straight to the requester while the line fills
  assign bypass     = state_q == S_WAIT && is_back && req_valid && req_pc[31:2] == fetch_addr_q[31:2];
  assign hit        = (req_valid && rd_valid && rd_tag == req_pc[31:LINE_BITS+2]) || bypass;
  assign hit_ins    = bypass ? back_ins : rd_data;
  assign is_fetch   = is_fetch_q;
  assign fetch_addr = fetch_addr_q;
  assign fill       = !rst_in && rdy_in && !rob_clear && state_q == S_WAIT && is_back;
  always_comb begin
    state_d      = state_q;
    is_fetch_d   = is_fetch_q;
    fetch_addr_d = fetch_addr_q;
    if (rdy_in) begin
      if (rob_clear) begin
        state_d    = S_IDLE;
        is_fetch_d = 1'b0;
      end else if (state_q == S_IDLE) begin
        is_fetch_d = req_valid && !hit;
        state_d    = is_fetch_d ? S_WAIT : S_IDLE;
        fetch_addr_d = is_fetch_d ? {req_pc[31:2], 2'b00} : fetch_addr_q;
      end else if (is_back) begin
        state_d    = S_IDLE;
        is_fetch_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      is_fetch_q   <= 1'b0;
      fetch_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      is_fetch_q   <= is_fetch_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end
endmodule

// File: tb/tb_inscache.sv
// tb_inscache: randomized + directed scoreboard bench against a line-level cache/memctrl model.
module tb_inscache;
  logic clk = 0, rst_in = 1, rdy_in = 1, rob_clear = 0, req_valid = 0, is_back = 0;
  logic [31:0] req_pc = 0, back_ins = 0, hit_ins, fetch_addr;
  logic hit, is_fetch;
  always #5 clk = ~clk;

  inscache dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .req_valid(req_valid), .req_pc(req_pc), .hit(hit), .hit_ins(hit_ins),
    .is_fetch(is_fetch), .fetch_addr(fetch_addr), .is_back(is_back), .back_ins(back_ins)
  );

  typedef struct {
    bit e_hit; bit [31:0] e_ins; bit e_fetch; bit [31:0] e_addr;
  } exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0;

  // model: a line per index holds (present, full tag, word); one pending miss or none
  bit        m_valid[64];
  int        m_tag[64];
  bit [31:0] m_data[64];
  bit        m_wait = 0;
  bit [31:0] m_addr = 0;
  int        cnt = 0, lat = 5;
  bit        en_chk = 0;

  function automatic bit [31:0] mem_word(input bit [31:0] a);
    return (a == 32'h1000) ? 32'h0000_0513 : (a * 32'h9E37_79B1) ^ 32'h0000_1234;
  endfunction

  // bk: 0 never, 1 when memctrl latency expires, 2 forced pulse
  task automatic step(input bit rv, input bit [31:0] pc, input bit rob, input bit rdy,
                      input bit rst, input int bk);
    exp_t e;
    int idx;
    bit bp;
    @(negedge clk);
    req_valid = rv; req_pc = pc; rob_clear = rob; rdy_in = rdy; rst_in = rst;
    is_back = (bk == 2) || (bk == 1 && m_wait && rdy && cnt >= lat);
    back_ins = is_back ? mem_word(m_addr) : $urandom;
    idx = (pc / 4) % 64;
    bp = m_wait && is_back && rv && (pc / 4) == (m_addr / 4);
    e.e_hit = (rv && m_valid[idx] && m_tag[idx] == int'(pc / 256)) || bp;
    e.e_ins = bp ? back_ins : m_data[idx];
    e.e_fetch = m_wait;
    e.e_addr = m_addr;
    if (en_chk) sb.push_back(e);
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_wait = 0; m_addr = 0; cnt = 0;
    end else if (rdy) begin
      if (rob) m_wait = 0;
      else if (!m_wait) begin
        if (rv && !e.e_hit) begin m_wait = 1; m_addr = pc & ~32'd3; end
      end else if (is_back) begin
        m_valid[(m_addr / 4) % 64] = 1;
        m_tag[(m_addr / 4) % 64] = int'(m_addr / 256);
        m_data[(m_addr / 4) % 64] = back_ins;
        m_wait = 0;
      end
      cnt = m_wait ? cnt + 1 : 0;
    end
    en_chk = 1;
  endtask

  task automatic chk(input string nm, input bit [31:0] act, input bit [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
  endtask

  always @(negedge clk) begin
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("hit", {31'd0, hit}, {31'd0, e.e_hit});
      if (e.e_hit) chk("hit_ins", hit_ins, e.e_ins);
      chk("is_fetch", {31'd0, is_fetch}, {31'd0, e.e_fetch});
      if (e.e_fetch) chk("fetch_addr", fetch_addr, e.e_addr);
    end
  end

  task automatic run(input int n, input bit [31:0] pc);
    repeat (n) step(1, pc, 0, 1, 0, 1);
  endtask

  initial begin
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    // cold miss with bypass, then zero-latency re-hit
    lat = 5;
    run(9, 32'h1000);
    run(3, 32'h1000);
    // conflicting tag on the same index evicts the earlier line
    run(9, 32'h1100);
    run(9, 32'h1000);
    // long memctrl stall while other lines keep hitting
    run(9, 32'h2004);
    lat = 20;
    step(1, 32'h3000, 0, 1, 0, 1);
    for (int i = 0; i < 24; i++) step(1, (i % 2) ? 32'h3000 : 32'h2004, 0, 1, 0, 1);
    // flush coincident with the returning word
    lat = 3;
    step(1, 32'h4000, 0, 1, 0, 1);
    for (int i = 0; i < 10 && (!m_wait || cnt < lat); i++) step(0, 32'h4000, 0, 1, 0, 0);
    step(1, 32'h4000, 1, 1, 0, 1);
    step(0, 32'h4000, 0, 1, 0, 0);
    step(1, 32'h2004, 0, 1, 0, 1);
    step(1, 32'h1000, 0, 1, 0, 1);
    // freeze mid-wait with a stray return pulse, then reset mid-wait
    lat = 10;
    step(1, 32'h5000, 0, 1, 0, 1);
    step(0, 32'h5000, 0, 1, 0, 1);
    step(0, 32'h5000, 0, 0, 0, 0);
    step(1, 32'h5000, 0, 0, 0, 2);
    step(0, 32'h5000, 0, 0, 0, 0);
    step(1, 32'h5000, 0, 1, 0, 0);
    step(0, 32'h5000, 0, 1, 1, 0);
    step(1, 32'h2004, 0, 1, 0, 0);
    step(1, 32'h1000, 0, 1, 0, 0);
    // random traffic over a small set of conflicting addresses
    for (int i = 0; i < 3000; i++) begin
      bit [31:0] pc;
      pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if (!m_wait) lat = $urandom_range(0, 8);
      step($urandom_range(0, 3) != 0, pc, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 40) == 0 ? 2 : 1);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #5;
    if (sb.size() > 0) chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
